mem_arbiter: RTL

Two-requester arbiter sharing the single physical memory port (the `pmem` DPI bridge) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the npc core. Both requesters are decoupled from the memory with valid/ready handshakes. The block owns the port for exactly one outstanding transaction at a time, routes the response back to the issuing requester, and flags a memory response timeout.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-port handshakes around mem_arbiter.
// The arb modport is the arbiter's view; env is the view of whatever drives it.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic [1:0]  lsu_size;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [1:0]  mem_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        timeout;

    modport arb (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
        output timeout
    );

    modport env (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
        input  timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter for the single pmem port: one outstanding transaction, sticky response timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IFU.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    mem_arbiter_if.arb bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT);

    state_t      r_state;
    logic        r_owner;
    logic        r_memReqValid;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [1:0]  r_size;
    logic [15:0] r_waitCount;
    logic        r_timeout;

    logic        w_anyReq;
    logic        w_grantLsu;
    logic        w_accept;
    logic        w_inWait;
    logic        w_rspHit;
    logic        w_expire;
    logic        w_rspFire;
    logic [16:0] w_waitNext;

`ifdef MEM_ARB_RR_EN
    logic        r_rrPtr;

    // r_rrPtr names the preferred requester; it only matters when both ask at once.
    assign w_grantLsu = (bus.ifu_req_valid && bus.lsu_req_valid) ? r_rrPtr : bus.lsu_req_valid;
`else
    assign w_grantLsu = bus.lsu_req_valid;
`endif

    assign w_anyReq   = bus.ifu_req_valid || bus.lsu_req_valid;
    assign w_accept   = (r_state == IDLE) && w_anyReq && !reset;

    assign bus.ifu_req_ready = w_accept && !w_grantLsu;
    assign bus.lsu_req_ready = w_accept && w_grantLsu;

    // A response arriving in the very cycle the budget runs out still counts as a normal response.
    assign w_inWait   = (r_state == WAIT) && !reset;
    assign w_waitNext = {1'b0, r_waitCount} + 17'd1;
    assign w_rspHit   = w_inWait && bus.mem_rsp_valid;
    assign w_expire   = w_inWait && !bus.mem_rsp_valid && (w_waitNext == TIMEOUT_LIMIT);
    assign w_rspFire  = w_rspHit || w_expire;

    assign bus.ifu_rsp_valid = w_rspFire && (r_owner == OWNER_IFU);
    assign bus.lsu_rsp_valid = w_rspFire && (r_owner == OWNER_LSU);
    assign bus.ifu_rdata     = (w_rspHit && (r_owner == OWNER_IFU)) ? bus.mem_rdata : 32'd0;
    assign bus.lsu_rdata     = (w_rspHit && (r_owner == OWNER_LSU)) ? bus.mem_rdata : 32'd0;

    assign bus.mem_req_valid = r_memReqValid;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wmask     = r_wmask;
    assign bus.mem_size      = r_size;
    assign bus.timeout       = r_timeout;

    // Holding registers load only on a grant, so the memory sees stable fields until it accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= OWNER_IFU;
            r_memReqValid <= 1'b0;
            r_addr        <= 32'd0;
            r_wen         <= 1'b0;
            r_wdata       <= 32'd0;
            r_wmask       <= 8'd0;
            r_size        <= 2'd0;
            r_waitCount   <= 16'd0;
            r_timeout     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_rrPtr       <= OWNER_IFU;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= REQ;
                        r_memReqValid <= 1'b1;
                        r_owner       <= w_grantLsu;
`ifdef MEM_ARB_RR_EN
                        r_rrPtr       <= ~w_grantLsu;
`endif
                        if (w_grantLsu) begin
                            r_addr  <= bus.lsu_addr;
                            r_wen   <= bus.lsu_wen;
                            r_wdata <= bus.lsu_wdata;
                            r_wmask <= bus.lsu_wmask;
                            r_size  <= bus.lsu_size;
                        end else begin
                            r_addr  <= bus.ifu_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= 32'd0;
                            r_wmask <= 8'd0;
                            r_size  <= 2'd2;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_state       <= WAIT;
                        r_memReqValid <= 1'b0;
                        r_waitCount   <= 16'd0;
                    end
                end
                WAIT: begin
                    if (w_rspHit) begin
                        r_state <= IDLE;
                    end else if (w_expire) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_waitCount <= r_waitCount + 16'd1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_memReqValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
